// File: rtl/ibex_rvfi_trace_packer.sv
// RVFI trace packer: buffers retired instructions in a packet FIFO and serialises each as a
// 32-bit valid/ready word stream. Define RVFI_PACK_MEM_EN to append MADDR/MDATA words to memory packets.
module ibex_rvfi_trace_packer #(
    parameter int FifoDepth = 4,
    parameter int DropCntW  = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                enable_i,
    input  logic                rvfi_valid,
    input  logic                rvfi_trap,
    input  logic                rvfi_halt,
    input  logic                rvfi_intr,
    input  logic [1:0]          rvfi_mode,
    input  logic [4:0]          rvfi_rd_addr,
    input  logic [31:0]         rvfi_rd_wdata,
    input  logic [31:0]         rvfi_pc_rdata,
    input  logic [31:0]         rvfi_insn,
    input  logic [31:0]         rvfi_mem_addr,
    input  logic [3:0]          rvfi_mem_rmask,
    input  logic [3:0]          rvfi_mem_wmask,
    input  logic [31:0]         rvfi_mem_rdata,
    input  logic [31:0]         rvfi_mem_wdata,
    output logic                tx_valid_o,
    input  logic                tx_ready_i,
    output logic [31:0]         tx_data_o,
    output logic                tx_last_o,
    output logic                fifo_full_o,
    output logic [DropCntW-1:0] drop_cnt_o
);

    localparam int PtrW = $clog2(FifoDepth);
    localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(FifoDepth);

    typedef enum logic [2:0] {IDLE, HDR, PC, INSN, WDATA, MADDR, MDATA} state_e;

    state_e state, state_next;

    logic [PtrW:0]   wr_ptr, rd_ptr, wr_next, rd_next;
    logic [PtrW-1:0] wr_idx, rd_idx;
    logic            ovf_pend;
    logic            capture, push, pop, drop, fifo_nonempty_next;

    // meta = {ovf, trap, halt, intr, mode[1:0], rd[4:0], rmask[3:0], wmask[3:0]}
    logic [18:0] meta_q  [FifoDepth];
    logic [31:0] pc_q    [FifoDepth];
    logic [31:0] insn_q  [FifoDepth];
    logic [31:0] wdata_q [FifoDepth];
`ifdef RVFI_PACK_MEM_EN
    logic [31:0] maddr_q [FifoDepth];
    logic [31:0] mdata_q [FifoDepth];
`else
    logic unused_mem;
    assign unused_mem = ^{rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata};
`endif

    logic [18:0] head_meta;
    logic        head_mem, head_long;
    logic [3:0]  head_cnt;
    logic [31:0] header;

    assign wr_idx = wr_ptr[PtrW-1:0];
    assign rd_idx = rd_ptr[PtrW-1:0];

    assign head_meta = meta_q[rd_idx];
    assign head_mem  = |(head_meta[7:4] | head_meta[3:0]);
`ifdef RVFI_PACK_MEM_EN
    assign head_long = head_mem;
`else
    assign head_long = 1'b0;
`endif
    assign head_cnt  = head_long ? 4'd6 : 4'd4;
    assign header    = {8'hA5, head_meta[18:8], head_mem, head_meta[7:0], head_cnt};

    // A full FIFO may still accept a retire when its head packet leaves on the same edge.
    always_comb begin
        capture            = rvfi_valid & enable_i;
        pop                = tx_valid_o & tx_ready_i & tx_last_o;
        push               = capture & (~fifo_full_o | pop);
        drop               = capture & ~push;
        wr_next            = wr_ptr + (PtrW + 1)'(push);
        rd_next            = rd_ptr + (PtrW + 1)'(pop);
        fifo_nonempty_next = (wr_next != rd_next);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_full_o <= 1'b0;
            drop_cnt_o  <= '0;
            ovf_pend    <= 1'b0;
            state       <= IDLE;
        end else begin
            wr_ptr      <= wr_next;
            rd_ptr      <= rd_next;
            fifo_full_o <= ((wr_next - rd_next) == DepthCnt);
            state       <= state_next;
            if (push) begin
                ovf_pend <= 1'b0;
            end else if (drop) begin
                ovf_pend <= 1'b1;
            end
            if (drop && (drop_cnt_o != '1)) begin
                drop_cnt_o <= drop_cnt_o + DropCntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            meta_q[wr_idx]  <= {ovf_pend, rvfi_trap, rvfi_halt, rvfi_intr, rvfi_mode,
                                rvfi_rd_addr, rvfi_mem_rmask, rvfi_mem_wmask};
            pc_q[wr_idx]    <= rvfi_pc_rdata;
            insn_q[wr_idx]  <= rvfi_insn;
            wdata_q[wr_idx] <= rvfi_rd_wdata;
`ifdef RVFI_PACK_MEM_EN
            maddr_q[wr_idx] <= rvfi_mem_addr;
            mdata_q[wr_idx] <= (rvfi_mem_wmask != 4'd0) ? rvfi_mem_wdata : rvfi_mem_rdata;
`endif
        end
    end

    // IDLE looks at next-cycle occupancy so a retire into an empty FIFO shows its header one cycle later.
    always_comb begin
        state_next = state;
        tx_valid_o = 1'b0;
        tx_data_o  = 32'h0;
        tx_last_o  = 1'b0;
        unique case (state)
            IDLE: begin
                if (fifo_nonempty_next) state_next = HDR;
            end
            HDR: begin
                tx_valid_o = 1'b1;
                tx_data_o  = header;
                if (tx_ready_i) state_next = PC;
            end
            PC: begin
                tx_valid_o = 1'b1;
                tx_data_o  = pc_q[rd_idx];
                if (tx_ready_i) state_next = INSN;
            end
            INSN: begin
                tx_valid_o = 1'b1;
                tx_data_o  = insn_q[rd_idx];
                if (tx_ready_i) state_next = WDATA;
            end
            WDATA: begin
                tx_valid_o = 1'b1;
                tx_data_o  = wdata_q[rd_idx];
                tx_last_o  = ~head_long;
                if (tx_ready_i) begin
                    if (head_long) state_next = MADDR;
                    else           state_next = fifo_nonempty_next ? HDR : IDLE;
                end
            end
            MADDR: begin
                tx_valid_o = 1'b1;
`ifdef RVFI_PACK_MEM_EN
                tx_data_o  = maddr_q[rd_idx];
`endif
                if (tx_ready_i) state_next = MDATA;
            end
            MDATA: begin
                tx_valid_o = 1'b1;
`ifdef RVFI_PACK_MEM_EN
                tx_data_o  = mdata_q[rd_idx];
`endif
                tx_last_o  = 1'b1;
                if (tx_ready_i) state_next = fifo_nonempty_next ? HDR : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ibex_rvfi_trace_packer.sv
// Testbench for ibex_rvfi_trace_packer: hand-computed header table, directed corner
// sequences and random traffic, all checked against a packet-level queue model.
module tb_ibex_rvfi_trace_packer;

    localparam int FIFO_DEPTH = 4;
    localparam int DROP_MAX   = 65535;

    typedef struct packed {
        logic        trap;
        logic        halt;
        logic        intr;
        logic [1:0]  mode;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] maddr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] mrdata;
        logic [31:0] mwdata;
    } rv_t;

    typedef struct packed {
        logic [5:0][31:0] w;
        logic [3:0]       n;
    } pkt_t;

    typedef struct packed {
        rv_t         in;
        logic [31:0] exp_hdr;
    } tv_t;

    logic        clk = 1'b0;
    logic        rst_i, enable_i, rvfi_valid, rvfi_trap, rvfi_halt, rvfi_intr;
    logic [1:0]  rvfi_mode;
    logic [4:0]  rvfi_rd_addr;
    logic [31:0] rvfi_rd_wdata, rvfi_pc_rdata, rvfi_insn, rvfi_mem_addr;
    logic [3:0]  rvfi_mem_rmask, rvfi_mem_wmask;
    logic [31:0] rvfi_mem_rdata, rvfi_mem_wdata;
    logic        tx_valid_o, tx_ready_i, tx_last_o, fifo_full_o;
    logic [31:0] tx_data_o;
    logic [15:0] drop_cnt_o;

    int   checks = 0;
    int   errors = 0;
    pkt_t pkt_q[$];
    int   idx    = 0;
    int   m_drop = 0;
    bit   m_ovf  = 1'b0;

    always #5 clk = ~clk;

    ibex_rvfi_trace_packer #(.FifoDepth(FIFO_DEPTH), .DropCntW(16)) dut (
        .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .rvfi_valid(rvfi_valid),
        .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt), .rvfi_intr(rvfi_intr),
        .rvfi_mode(rvfi_mode), .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
        .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_insn(rvfi_insn), .rvfi_mem_addr(rvfi_mem_addr),
        .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
        .rvfi_mem_rdata(rvfi_mem_rdata), .rvfi_mem_wdata(rvfi_mem_wdata),
        .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i), .tx_data_o(tx_data_o),
        .tx_last_o(tx_last_o), .fifo_full_o(fifo_full_o), .drop_cnt_o(drop_cnt_o)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic rv_t mk(input logic [31:0] pc, input logic [31:0] insn, input logic [4:0] rd,
                               input logic [31:0] wdata, input logic [1:0] mode, input logic trap,
                               input logic halt, input logic intr, input logic [3:0] rmask,
                               input logic [3:0] wmask, input logic [31:0] maddr,
                               input logic [31:0] mwdata, input logic [31:0] mrdata);
        rv_t r;
        r.pc = pc; r.insn = insn; r.rd = rd; r.wdata = wdata; r.mode = mode;
        r.trap = trap; r.halt = halt; r.intr = intr; r.rmask = rmask; r.wmask = wmask;
        r.maddr = maddr; r.mwdata = mwdata; r.mrdata = mrdata;
        return r;
    endfunction

    function automatic rv_t rand_rv();
        rv_t r;
        r = mk($urandom, $urandom, 5'($urandom), $urandom, 2'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom), $urandom, $urandom, $urandom);
        if ($urandom_range(0, 2) == 0) begin
            r.rmask = 4'd0;
            r.wmask = 4'd0;
        end
        return r;
    endfunction

    // Packet contents straight from the documented word format.
    function automatic pkt_t make_pkt(input rv_t r, input bit ovf);
        pkt_t p;
        logic mem, long_pkt;
        mem = ((r.rmask | r.wmask) != 4'd0);
`ifdef RVFI_PACK_MEM_EN
        long_pkt = mem;
`else
        long_pkt = 1'b0;
`endif
        p.w    = '0;
        p.n    = long_pkt ? 4'd6 : 4'd4;
        p.w[0] = 32'hA500_0000 | (32'(ovf) << 23) | (32'(r.trap) << 22) | (32'(r.halt) << 21)
               | (32'(r.intr) << 20) | (32'(r.mode) << 18) | (32'(r.rd) << 13) | (32'(mem) << 12)
               | (32'(r.rmask) << 8) | (32'(r.wmask) << 4) | 32'(p.n);
        p.w[1] = r.pc;
        p.w[2] = r.insn;
        p.w[3] = r.wdata;
        p.w[4] = r.maddr;
        p.w[5] = (r.wmask != 4'd0) ? r.mwdata : r.mrdata;
        return p;
    endfunction

    task automatic checkStream();
        bit exp_valid;
        exp_valid = (pkt_q.size() != 0);
        checkOutput("tx_valid", 32'(tx_valid_o), 32'(exp_valid));
        if (exp_valid) begin
            checkOutput("tx_data", tx_data_o, pkt_q[0].w[idx]);
            checkOutput("tx_last", 32'(tx_last_o), 32'(idx == int'(pkt_q[0].n) - 1));
        end else begin
            checkOutput("tx_last_idle", 32'(tx_last_o), 32'd0);
        end
        checkOutput("fifo_full", 32'(fifo_full_o), 32'(pkt_q.size() == FIFO_DEPTH));
        checkOutput("drop_cnt", 32'(drop_cnt_o), 32'(m_drop));
    endtask

    task automatic modelUpdate(input logic v, input logic en, input logic rdy, input logic rst, input rv_t r);
        bit hs, last_hs;
        int occ;
        hs      = (pkt_q.size() != 0) && rdy;
        last_hs = hs && (idx == int'(pkt_q[0].n) - 1);
        occ     = pkt_q.size();
        if (rst) begin
            pkt_q.delete();
            idx    = 0;
            m_drop = 0;
            m_ovf  = 1'b0;
        end else begin
            if (hs) idx++;
            if (last_hs) begin
                void'(pkt_q.pop_front());
                idx = 0;
            end
            if (v && en) begin
                if (occ < FIFO_DEPTH || last_hs) begin
                    pkt_q.push_back(make_pkt(r, m_ovf));
                    m_ovf = 1'b0;
                end else begin
                    if (m_drop < DROP_MAX) m_drop++;
                    m_ovf = 1'b1;
                end
            end
        end
    endtask

    // One clock cycle: drive at the falling edge, check before the rising edge, then advance the model.
    task automatic applyStimulus(input logic v, input logic en, input logic rdy, input logic rst, input rv_t r);
        @(negedge clk);
        rst_i = rst; enable_i = en; rvfi_valid = v; tx_ready_i = rdy;
        rvfi_trap = r.trap; rvfi_halt = r.halt; rvfi_intr = r.intr; rvfi_mode = r.mode;
        rvfi_rd_addr = r.rd; rvfi_rd_wdata = r.wdata; rvfi_pc_rdata = r.pc; rvfi_insn = r.insn;
        rvfi_mem_addr = r.maddr; rvfi_mem_rmask = r.rmask; rvfi_mem_wmask = r.wmask;
        rvfi_mem_rdata = r.mrdata; rvfi_mem_wdata = r.mwdata;
        #1;
        checkStream();
        modelUpdate(v, en, rdy, rst, r);
    endtask

    initial begin
        tv_t         tbl [5];
        rv_t         alu;
        logic [31:0] hdr;

        tbl[0].in = mk(32'h80, 32'h00500093, 5'd1, 32'd5, 2'd0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0);
        tbl[0].exp_hdr = 32'hA500_2004;
        tbl[1].in = mk(32'h100, 32'h00000073, 5'd0, 32'd0, 2'd3, 1, 0, 0, 4'h0, 4'h0, 0, 0, 0);
        tbl[1].exp_hdr = 32'hA54C_0004;
        tbl[2].in = mk(32'h204, 32'h00A02023, 5'd0, 32'd0, 2'd3, 0, 0, 0, 4'h0, 4'hF,
                       32'h1000, 32'hDEADBEEF, 32'h0);
        tbl[2].exp_hdr = 32'hA50C_10F4;
        tbl[3].in = mk(32'h208, 32'h00001503, 5'd10, 32'h1234, 2'd3, 0, 0, 0, 4'h3, 4'h0,
                       32'h2000, 32'h0, 32'h5678_1234);
        tbl[3].exp_hdr = 32'hA50D_5304;
        tbl[4].in = mk(32'h300, 32'h00100073, 5'd31, 32'hFFFF_FFFF, 2'd0, 0, 1, 1, 4'h0, 4'h0, 0, 0, 0);
        tbl[4].exp_hdr = 32'hA533_E004;

        rst_i = 1'b1; enable_i = 1'b0; rvfi_valid = 1'b0; tx_ready_i = 1'b0;
        rvfi_trap = 0; rvfi_halt = 0; rvfi_intr = 0; rvfi_mode = '0; rvfi_rd_addr = '0;
        rvfi_rd_wdata = '0; rvfi_pc_rdata = '0; rvfi_insn = '0; rvfi_mem_addr = '0;
        rvfi_mem_rmask = '0; rvfi_mem_wmask = '0; rvfi_mem_rdata = '0; rvfi_mem_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("rst_valid", 32'(tx_valid_o), 32'd0);
        checkOutput("rst_last", 32'(tx_last_o), 32'd0);
        checkOutput("rst_data", tx_data_o, 32'd0);
        checkOutput("rst_full", 32'(fifo_full_o), 32'd0);
        checkOutput("rst_drop", 32'(drop_cnt_o), 32'd0);

        // Table: one retire, header checked against the hand-computed value, then drained.
        for (int i = 0; i < 5; i++) begin
            hdr = tbl[i].exp_hdr;
`ifdef RVFI_PACK_MEM_EN
            if ((tbl[i].in.rmask | tbl[i].in.wmask) != 4'd0) hdr[3:0] = 4'd6;
`endif
            applyStimulus(1, 1, 0, 0, tbl[i].in);
            applyStimulus(0, 1, 0, 0, '0);
            checkOutput("tbl_valid", 32'(tx_valid_o), 32'd1);
            checkOutput("tbl_hdr", tx_data_o, hdr);
            repeat (8) applyStimulus(0, 1, 1, 0, '0);
        end

        // Back-pressure for 10 cycles in the middle of a packet, with a retire during the stall.
        alu = tbl[0].in;
        applyStimulus(1, 1, 1, 0, alu);
        applyStimulus(0, 1, 1, 0, '0);
        applyStimulus(0, 1, 1, 0, '0);
        for (int i = 0; i < 10; i++) applyStimulus(i == 5, 1, 0, 0, rand_rv());
        repeat (12) applyStimulus(0, 1, 1, 0, '0);

        // Overflow: retire every cycle while stalled; the fifth is dropped.
        for (int i = 0; i < 5; i++) applyStimulus(1, 1, 0, 0, rand_rv());
        applyStimulus(0, 1, 0, 0, '0);
        checkOutput("ovf_drop", 32'(drop_cnt_o), 32'd1);
        checkOutput("ovf_full", 32'(fifo_full_o), 32'd1);

        // Full FIFO, retire on the cycle the head's last word leaves: accepted, no new drop.
        applyStimulus(0, 1, 1, 0, '0);
        applyStimulus(0, 1, 1, 0, '0);
        applyStimulus(0, 1, 1, 0, '0);
        applyStimulus(1, 1, 1, 0, alu);
        applyStimulus(0, 1, 0, 0, '0);
        checkOutput("popush_drop", 32'(drop_cnt_o), 32'd1);
        checkOutput("popush_full", 32'(fifo_full_o), 32'd1);
        repeat (30) applyStimulus(0, 1, 1, 0, '0);

        // Retire ignored while capture is disabled.
        applyStimulus(1, 0, 1, 0, alu);
        applyStimulus(0, 1, 1, 0, '0);

        // Reset while the INSN word is on the bus.
        applyStimulus(1, 1, 1, 0, alu);
        applyStimulus(0, 1, 1, 0, '0);
        applyStimulus(0, 1, 1, 0, '0);
        applyStimulus(0, 1, 0, 1, '0);
        applyStimulus(0, 1, 1, 0, '0);
        checkOutput("mid_rst_valid", 32'(tx_valid_o), 32'd0);
        checkOutput("mid_rst_drop", 32'(drop_cnt_o), 32'd0);
        checkOutput("mid_rst_full", 32'(fifo_full_o), 32'd0);
        applyStimulus(1, 1, 1, 0, alu);
        applyStimulus(0, 1, 1, 0, '0);
        checkOutput("post_rst_hdr", 32'(tx_data_o[31:24]), 32'hA5);
        repeat (6) applyStimulus(0, 1, 1, 0, '0);

        // Random traffic with bursts of retires, stalls and the occasional reset.
        for (int i = 0; i < 1500; i++) begin
            applyStimulus($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 90,
                          $urandom_range(0, 99) < 55, $urandom_range(0, 399) == 0, rand_rv());
        end

        for (int i = 0; i < 50 && pkt_q.size() != 0; i++) applyStimulus(0, 1, 1, 0, '0);
        checkOutput("final_drain", 32'(pkt_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
